imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader that sits directly upstream of the instruction memory.
//  It receives a framed byte stream over a valid/ready interface and assembles
//  big-endian 32-bit instruction words. It writes each word into the instruction
//  RAM through a dedicated write port.
//  It holds the processor core in reset until a complete, checksum-correct image is loaded.
// PARAMETERS
//  ADDR_W  6   instruction RAM word-address width; DEPTH = 2**ADDR_W words (64)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       1-cycle pulse: begin a new load (honoured only in IDLE, DONE, ERR)
//  rx_data      in   8       incoming frame byte
//  rx_valid     in   1       rx_data is valid
//  rx_ready     out  1       loader accepts a byte this cycle
//  imem_we      out  1       instruction RAM write strobe (1 cycle per word)
//  imem_waddr   out  ADDR_W  instruction RAM word index
//  imem_wdata   out  32      instruction word
//  core_reset   out  1       reset to the core; 1 unless the loader is in DONE
//  load_done    out  1       image loaded and checksum correct (level)
//  load_err     out  1       length or checksum error (level)
// BEHAVIOUR
//  Frame layout: LEN_HI, LEN_LO (N = 16-bit word count), 4*N payload bytes (MSB first), CHK.
//  CHK = XOR of all 4*N payload bytes. Length bytes are excluded.
//  Byte accept: rx_valid && rx_ready. rx_ready=1 only in LEN_HI, LEN_LO, DATA and CHECK.
//  FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
//   IDLE  -start-> LEN_HI. Also DONE -start-> LEN_HI and ERR -start-> LEN_HI.
//   On any start transition: clear load_done, load_err, the byte count, the word address and the checksum.
//   LEN_HI -byte-> LEN_LO.
//   LEN_LO -byte-> DATA if 1 <= N <= DEPTH; CHECK if N = 0; ERR if N > DEPTH.
//   DATA: shift each accepted byte into a 32-bit accumulator (first byte -> [31:24]) and XOR it into the checksum.
//   On the 4th byte of a word: register the word and the address, then pulse imem_we on the next cycle.
//   After each write, imem_waddr increments.
//   DATA -> CHECK on acceptance of byte 4*N.
//   CHECK -byte-> DONE if byte == checksum; otherwise ERR.
//   DONE: load_done=1, core_reset=0. ERR: load_err=1, core_reset=1.
//   start is ignored in LEN_HI, LEN_LO, DATA and CHECK (no restart mid-frame).
//  Latency: imem_we rises exactly 1 cycle after the 4th byte of a word is accepted.
//   A full-rate stream (rx_valid held high) is never back-pressured by the write.
//   The final imem_we pulse coincides with the first cycle in CHECK.
//  Width rules: the word address is ADDR_W bits and never wraps.
//   N > DEPTH is rejected before any write. N = DEPTH writes indices 0..DEPTH-1.
//  Words written before an ERR remain in RAM. The core stays in reset, so they are never executed.
//  rx_data is ignored whenever rx_ready = 0.
//  Reset values (asynchronous, immediate): state=IDLE, rx_ready=0, imem_we=0, imem_waddr=0,
//   imem_wdata=0, core_reset=1, load_done=0, load_err=0, checksum=0, counters=0.
//  Reset mid-frame aborts the load. It returns to IDLE with no further imem_we, and a new start is required.
// TESTING
//  1 start; bytes 00 02 | 20 01 00 05 | 08 00 00 04 | CHK=20^01^05^08^04=28
//    -> imem_we at waddr 0 (data 0x20010005), then at waddr 1 (data 0x08000004);
//       then load_done=1, core_reset=0.
//  2 Same frame, last byte 0x29 -> load_err=1, load_done=0, core_reset stays 1; two writes still observed.
//  3 Length 00 41 (65 > 64) -> ERR directly after LEN_LO; zero imem_we pulses; rx_ready=0.
//  4 Length 00 00, CHK=00 -> DONE with no writes.
//    Length 00 40 -> 64 writes; last waddr=63; no wrap.
//  5 rx_valid toggled randomly plus 1 byte per 3 cycles -> same RAM contents and flags as test 1;
//    each imem_we is 1 cycle wide.
//  6 reset asserted after 5 payload bytes -> outputs return to reset values immediately.
//    A start during DATA is ignored. A start from DONE reloads and core_reset rises to 1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: parses a LEN_HI/LEN_LO/payload/CHK byte frame and writes big-endian words into instruction RAM.
// Holds the core in reset until a complete, checksum-correct image has been written.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_word_cnt;
  logic [23:0]       r_acc;
  logic [7:0]        r_chk;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;

  logic              w_accept;
  logic              w_start_ok;
  logic              w_word_end;
  logic              w_last_word;
  logic [15:0]       w_len_in;

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready; rx_ready depends on state only.
  assign rx_ready    = r_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
  assign w_accept    = rx_valid && rx_ready;
  assign w_start_ok  = start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_word_end  = (r_state == S_DATA) && w_accept && (r_byte_idx == 2'd3);
  assign w_last_word = (16'(r_word_cnt) + 16'd1) == r_len;
  assign w_len_in    = {r_len_hi, rx_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        // Oversized images are rejected here, before any RAM write can happen.
        if (w_accept) begin
          if (w_len_in == 16'd0)              w_next = S_CHECK;
          else if ({1'b0, w_len_in} > DEPTH)  w_next = S_ERR;
          else                                w_next = S_DATA;
        end
      end
      S_DATA:  if (w_word_end && w_last_word) w_next = S_CHECK;
      S_CHECK: if (w_accept) w_next = (rx_data == r_chk) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_acc      <= '0;
      r_chk      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_byte_idx <= '0;
        r_word_cnt <= '0;
        r_waddr    <= '0;
        r_chk      <= '0;
        r_acc      <= '0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_len_hi <= rx_data;
          S_LEN_LO: r_len    <= w_len_in;
          S_DATA: begin
            r_chk      <= r_chk ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            // Separate word counter keeps the address at DEPTH-1 after a full image instead of wrapping.
            if (r_byte_idx == 2'd3) begin
              r_we       <= 1'b1;
              r_wdata    <= {r_acc, rx_data};
              r_waddr    <= r_word_cnt[ADDR_W-1:0];
              r_word_cnt <= r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
              r_acc <= {r_acc[15:0], rx_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign core_reset = (r_state != S_DONE);
  assign load_done  = (r_state == S_DONE);
  assign load_err   = (r_state == S_ERR);
  assign dbg_state  = r_state;

endmodule
